tapdelay_sequencer: RTL and testbench

Tapped-delay-line controller for the NAR network input path. It stores each incoming sample in a circular history buffer of NUM_TAPS entries. It then streams the full tap vector, newest to oldest, to the downstream MAC datapath over a valid/ready handshake. Internally it sequences a wrap-around write pointer and a read pointer equivalent to the 5-bit tap delay counter, which counts 0..NUM_TAPS-1 and then wraps.

---
 rtl/tapdelay_sequencer.sv | 119 +++++++++++
 tb/tb_tapdelay_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tapdelay_sequencer.sv
// Tapped-delay-line controller: keeps a circular history of the last NUM_TAPS
// samples and, for every accepted sample, streams the whole tap vector
// (newest first) to the MAC datapath over a valid/ready handshake.
module tapdelay_sequencer #(
   parameter int NUM_TAPS = 17,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tap_valid,
   input  logic              tap_ready,
   output logic [DATA_W-1:0] tap_data,
   output logic [4:0]        tap_index,
   output logic              tap_last,
   output logic              primed
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_TAPS - 1);
   localparam logic [5:0] FULL_CNT = 6'(NUM_TAPS);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t            state_reg;
   logic [4:0]        wr_ptr_reg;
   logic [4:0]        rd_ptr_reg;
   logic [4:0]        rd_next;
   logic [5:0]        fill_reg;
   logic              accept_in;
   logic              accept_tap;

   // The read mux always spans the full 5-bit pointer space; entries at or
   // above NUM_TAPS are constant zero and can never be addressed anyway.
   logic [DATA_W-1:0] hist [32];

   // in_ready is a function of state and reset only, never of tap_ready.
   assign in_ready   = !rst && (state_reg == IDLE);
   assign accept_in  = in_valid && in_ready;
   assign accept_tap = tap_valid && tap_ready;
   assign rd_next    = (rd_ptr_reg == 5'd0) ? LAST_IDX : rd_ptr_reg - 5'd1;
   assign primed     = (fill_reg == FULL_CNT);

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_hist
         if (gi < NUM_TAPS) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            // History entry: cleared by reset, written when the write pointer selects it.
            always_ff @(posedge clk) begin
               if (rst) begin
                  entry_reg <= '0;
               end else if (accept_in && (wr_ptr_reg == 5'(gi))) begin
                  entry_reg <= in_data;
               end
            end

            assign hist[gi] = entry_reg;
         end else begin : g_unused
            assign hist[gi] = '0;
         end
      end
   endgenerate

   // Sequencer FSM: accept one sample in IDLE, then walk the taps newest to oldest.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= 5'd0;
         rd_ptr_reg <= 5'd0;
         fill_reg   <= 6'd0;
         tap_valid  <= 1'b0;
         tap_data   <= '0;
         tap_index  <= 5'd0;
         tap_last   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept_in) begin
                  // The new sample is tap 0; bypass it straight to the output
                  // since the history write lands on this same edge.
                  tap_data   <= in_data;
                  tap_index  <= 5'd0;
                  tap_last   <= 1'b0;
                  tap_valid  <= 1'b1;
                  rd_ptr_reg <= wr_ptr_reg;
                  wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? 5'd0 : wr_ptr_reg + 5'd1;
                  if (fill_reg != FULL_CNT) begin
                     fill_reg <= fill_reg + 6'd1;
                  end
                  state_reg  <= STREAM;
               end
            end
            STREAM: begin
               if (accept_tap) begin
                  if (tap_last) begin
                     tap_valid <= 1'b0;
                     tap_last  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     rd_ptr_reg <= rd_next;
                     tap_data   <= hist[rd_next];
                     tap_index  <= tap_index + 5'd1;
                     tap_last   <= ((tap_index + 5'd1) == LAST_IDX);
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tapdelay_sequencer.sv
// Bench for tapdelay_sequencer: a default (17-tap) instance and a 2-tap
// instance, each with a history-queue reference model feeding a scoreboard
// that a negedge monitor drains.
module tb_tapdelay_sequencer;

   localparam int N1 = 17;
   localparam int N2 = 2;
   localparam int DW = 16;

   typedef struct {
      logic [DW-1:0] d;
      int            idx;
      bit            last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          in_valid1 = 1'b0, in_ready1, tap_valid1, tap_ready1, tap_last1, primed1;
   logic [DW-1:0] in_data1 = '0, tap_data1;
   logic [4:0]    tap_index1;

   logic          in_valid2 = 1'b0, in_ready2, tap_valid2, tap_ready2, tap_last2, primed2;
   logic [DW-1:0] in_data2 = '0, tap_data2;
   logic [4:0]    tap_index2;

   int            errors = 0;
   int            checks = 0;

   exp_t          q1[$];
   exp_t          q2[$];
   logic [DW-1:0] hist1[$];
   logic [DW-1:0] hist2[$];
   int            fill1 = 0;
   int            fill2 = 0;

   int            rmode = 0;
   int            rcnt  = 0;

   always #5 clk = ~clk;

   tapdelay_sequencer #(.NUM_TAPS(N1), .DATA_W(DW)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
      .tap_valid(tap_valid1), .tap_ready(tap_ready1), .tap_data(tap_data1),
      .tap_index(tap_index1), .tap_last(tap_last1), .primed(primed1)
   );

   tapdelay_sequencer #(.NUM_TAPS(N2), .DATA_W(DW)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
      .tap_valid(tap_valid2), .tap_ready(tap_ready2), .tap_data(tap_data2),
      .tap_index(tap_index2), .tap_last(tap_last2), .primed(primed2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: history is a newest-first list of NUM_TAPS samples.
   task automatic model_reset();
      hist1 = {};
      hist2 = {};
      for (int i = 0; i < N1; i++) hist1.push_back('0);
      for (int i = 0; i < N2; i++) hist2.push_back('0);
      fill1 = 0;
      fill2 = 0;
      q1.delete();
      q2.delete();
   endtask

   task automatic model_accept1(input logic [DW-1:0] d);
      exp_t e;
      hist1.push_front(d);
      void'(hist1.pop_back());
      for (int i = 0; i < N1; i++) begin
         e.d = hist1[i]; e.idx = i; e.last = (i == N1 - 1);
         q1.push_back(e);
      end
      if (fill1 < N1) fill1++;
   endtask

   task automatic model_accept2(input logic [DW-1:0] d);
      exp_t e;
      hist2.push_front(d);
      void'(hist2.pop_back());
      for (int i = 0; i < N2; i++) begin
         e.d = hist2[i]; e.idx = i; e.last = (i == N2 - 1);
         q2.push_back(e);
      end
      if (fill2 < N2) fill2++;
   endtask

   // Monitor: every cycle a tap is presented it must match the scoreboard head;
   // the head is retired only when the tap is actually transferred.
   always @(negedge clk) begin
      if (!rst && tap_valid1) begin
         chk("dut1_in_ready_in_stream", 32'(in_ready1), 32'd0);
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_unexpected_tap: got idx %0d data 0x%0h, required no tap", tap_index1, tap_data1);
         end else begin
            chk("dut1_tap_data", 32'(tap_data1), 32'(q1[0].d));
            chk("dut1_tap_index", 32'(tap_index1), 32'(q1[0].idx));
            chk("dut1_tap_last", 32'(tap_last1), 32'(q1[0].last));
            if (tap_ready1) begin
               $display("dut1 tap idx=%0d data=0x%04h last=%0b", tap_index1, tap_data1, tap_last1);
               void'(q1.pop_front());
            end
         end
      end
      if (!rst && tap_valid2) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut2_unexpected_tap: got idx %0d data 0x%0h, required no tap", tap_index2, tap_data2);
         end else begin
            chk("dut2_tap_data", 32'(tap_data2), 32'(q2[0].d));
            chk("dut2_tap_index", 32'(tap_index2), 32'(q2[0].idx));
            chk("dut2_tap_last", 32'(tap_last2), 32'(q2[0].last));
            if (tap_ready2) begin
               $display("dut2 tap idx=%0d data=0x%04h last=%0b", tap_index2, tap_data2, tap_last2);
               void'(q2.pop_front());
            end
         end
      end
   end

   // Downstream ready pattern: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
   initial begin
      tap_ready1 = 1'b1;
      tap_ready2 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       tap_ready1 = 1'b1;
            1:       tap_ready1 = 1'($urandom_range(0, 1));
            default: tap_ready1 = ((rcnt % 3) == 0);
         endcase
         rcnt++;
      end
   end

   // All tasks below are entered just after a rising edge.
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_tap_valid", 32'(tap_valid1), 32'd0);
      chk("rst_tap_data", 32'(tap_data1), 32'd0);
      chk("rst_tap_index", 32'(tap_index1), 32'd0);
      chk("rst_tap_last", 32'(tap_last1), 32'd0);
      chk("rst_primed", 32'(primed1), 32'd0);
      chk("rst_in_ready_low", 32'(in_ready1), 32'd0);
      chk("rst_dut2_tap_valid", 32'(tap_valid2), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready_after", 32'(in_ready1), 32'd1);
   endtask

   // Offer a sample; while the DUT is busy keep in_valid high with junk data.
   task automatic send1(input logic [DW-1:0] d);
      int guard = 0;
      in_valid1 = 1'b1;
      while (!in_ready1 && guard < 300) begin
         in_data1 = DW'($urandom);
         @(posedge clk);
         #1;
         guard++;
      end
      if (!in_ready1) begin
         checks++; errors++;
         $display("FAIL send1_timeout: got in_ready=0 after %0d cycles, required 1", guard);
         in_valid1 = 1'b0;
         return;
      end
      in_data1 = d;
      model_accept1(d);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
   endtask

   task automatic send2(input logic [DW-1:0] d);
      int guard = 0;
      in_valid2 = 1'b1;
      while (!in_ready2 && guard < 300) begin
         in_data2 = DW'($urandom);
         @(posedge clk);
         #1;
         guard++;
      end
      if (!in_ready2) begin
         checks++; errors++;
         $display("FAIL send2_timeout: got in_ready=0 after %0d cycles, required 1", guard);
         in_valid2 = 1'b0;
         return;
      end
      in_data2 = d;
      model_accept2(d);
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
   endtask

   task automatic wait_idle1();
      int guard = 0;
      while (!in_ready1 && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("dut1_idle_reached", 32'(in_ready1), 32'd1);
      chk("dut1_frame_drained", 32'(q1.size()), 32'd0);
   endtask

   task automatic wait_idle2();
      int guard = 0;
      while (!in_ready2 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("dut2_idle_reached", 32'(in_ready2), 32'd1);
      chk("dut2_frame_drained", 32'(q2.size()), 32'd0);
   endtask

   initial begin
      int n;
      @(posedge clk);
      #1;
      do_reset();

      // Single sample into a cleared history: latency and in_ready recovery.
      send1(16'h0011);
      chk("t1_valid_after_accept", 32'(tap_valid1), 32'd1);
      chk("t1_first_index", 32'(tap_index1), 32'd0);
      n = 0;
      while (!in_ready1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t1_in_ready_latency", 32'(n), 32'(N1));
      chk("t1_frame_drained", 32'(q1.size()), 32'd0);

      // Back-to-back samples 1..18: primed after the 17th, write pointer wraps.
      do_reset();
      for (int s = 1; s <= 18; s++) begin
         send1(DW'(s));
         chk("t2_primed", 32'(primed1), 32'(fill1 >= N1));
      end
      wait_idle1();

      // Downstream stalls: outputs must hold and no tap repeats or vanishes.
      rmode = 2;
      send1(16'h00AA);
      wait_idle1();
      rmode = 0;

      // Junk offered during STREAM must never reach the history.
      send1(16'h1234);
      send1(16'h5678);
      wait_idle1();

      // Reset while tap 5 is on the bus.
      send1(16'hBEEF);
      n = 0;
      while (tap_index1 != 5'd5 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t5_reached_index5", 32'(tap_index1), 32'd5);
      do_reset();
      send1(16'h0F0F);
      wait_idle1();

      // Randomised samples, gaps and downstream stalls.
      rmode = 1;
      for (int f = 0; f < 25; f++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send1(DW'($urandom));
      end
      wait_idle1();
      rmode = 0;
      chk("t6_primed", 32'(primed1), 32'd1);

      // Two-tap instance.
      do_reset();
      send2(16'h0001);
      chk("t7_primed_after_1", 32'(primed2), 32'd0);
      send2(16'h0002);
      chk("t7_primed_after_2", 32'(primed2), 32'd1);
      send2(16'h0003);
      wait_idle2();

      repeat (3) @(posedge clk);
      chk("end_q1_empty", 32'(q1.size()), 32'd0);
      chk("end_q2_empty", 32'(q2.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
